instr_stream_encoder: RTL and testbench

//  Producer side of the control-decode interface: encodes symbolic op requests into 32-bit MIPS words
//  (opcode/rs/rt/rd/shamt/funct, imm, target) that the control unit later decodes.

---
 rtl/instr_stream_encoder_if.sv | 31 +++
 rtl/instr_stream_encoder.sv | 104 ++++++++++
 tb/tb_instr_stream_encoder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_stream_encoder_if.sv
// Request/instruction-memory bundle between a program source and the instruction stream encoder.
// The slave side is the encoder; the master side drives requests and observes the imem write port.
interface instr_stream_encoder_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 7
);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_op;
   logic [4:0]        req_rs;
   logic [4:0]        req_rt;
   logic [4:0]        req_rd;
   logic [15:0]       req_imm;
   logic [25:0]       req_target;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [CNT_W-1:0]  word_count;
   logic              full;
   logic              err_illegal;

   modport slave (
      input  req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_target,
      output req_ready, imem_we, imem_addr, imem_wdata, word_count, full, err_illegal
   );

   modport master (
      output req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_target,
      input  req_ready, imem_we, imem_addr, imem_wdata, word_count, full, err_illegal
   );
endinterface

// File: rtl/instr_stream_encoder.sv
// Boot loader front end: encodes symbolic op requests into MIPS words and writes them
// sequentially into instruction memory, one word every two cycles, until DEPTH words are loaded.
module instr_stream_encoder #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       DEPTH     = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   instr_stream_encoder_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, WRITE, FULL} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              err_q, err_d;
   logic              legal;
   logic [31:0]       enc_word;
   logic              accept;

   // Only the ops the downstream control/ALU decoders understand map to a word.
   always_comb begin
      legal    = 1'b1;
      enc_word = '0;
      case (bus.req_op)
         4'd0:    enc_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h20};
         4'd1:    enc_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h22};
         4'd2:    enc_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h24};
         4'd3:    enc_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h25};
         4'd4:    enc_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h2A};
         4'd5:    enc_word = {6'h23, bus.req_rs, bus.req_rt, bus.req_imm};
         4'd6:    enc_word = {6'h2B, bus.req_rs, bus.req_rt, bus.req_imm};
         4'd7:    enc_word = {6'h04, bus.req_rs, bus.req_rt, bus.req_imm};
         4'd8:    enc_word = {6'h08, bus.req_rs, bus.req_rt, bus.req_imm};
         4'd9:    enc_word = {6'h02, bus.req_target};
         default: legal    = 1'b0;
      endcase
   end

   assign accept = bus.req_valid && bus.req_ready;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      count_d = count_q;
      err_d   = 1'b0;
      if (clr) begin
         // Restart wins over any request and abandons an in-flight write.
         state_d = IDLE;
         addr_d  = BASE_ADDR;
         count_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (legal) begin
                     wdata_d = enc_word;
                     state_d = WRITE;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            WRITE: begin
               addr_d  = addr_q + ADDR_W'(4);
               count_d = count_q + CNT_W'(1);
               state_d = (count_q + CNT_W'(1) == CNT_W'(DEPTH)) ? FULL : IDLE;
            end
            FULL:    state_d = FULL;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready   = (state_q == IDLE) && !rst && !clr;
   assign bus.imem_we     = (state_q == WRITE) && !rst && !clr;
   assign bus.imem_addr   = addr_q;
   assign bus.imem_wdata  = wdata_q;
   assign bus.word_count  = count_q;
   assign bus.full        = (state_q == FULL);
   assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: encoding table, directed corner sequences, and randomized
// traffic checked every cycle against a word-queue style reference model.
module tb_instr_stream_encoder;
   localparam int          DEPTH = 4;
   localparam int          CNT_W = $clog2(DEPTH + 1);
   localparam logic [31:0] BASE  = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst;
   logic clr;
   always #5 clk = ~clk;

   instr_stream_encoder_if #(.ADDR_W(32), .CNT_W(CNT_W)) bus ();

   instr_stream_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .bus(bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: a word awaiting its write slot, the next address, words loaded so far.
   bit          m_pending;
   logic [31:0] m_word;
   bit          m_word_chk;
   logic [31:0] m_addr;
   int          m_count;
   bit          m_err;

   bit          seen_we, seen_err, seen_full, seen_ready;
   logic [31:0] seen_word, seen_addr, seen_count;
   int          we_pulses;

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[11];

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
      logic [5:0] funct;
      logic [5:0] opc;
      funct = 6'h00;
      opc   = 6'h00;
      if (op <= 4) begin
         case (op)
            4'd0: funct = 6'h20;
            4'd1: funct = 6'h22;
            4'd2: funct = 6'h24;
            4'd3: funct = 6'h25;
            default: funct = 6'h2A;
         endcase
         return {6'h00, rs, rt, rd, 5'd0, funct};
      end
      if (op == 4'd9) return {6'h02, tgt};
      case (op)
         4'd5: opc = 6'h23;
         4'd6: opc = 6'h2B;
         4'd7: opc = 6'h04;
         default: opc = 6'h08;
      endcase
      return {opc, rs, rt, imm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit v, input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
      bus.req_valid  = v;
      bus.req_op     = op;
      bus.req_rs     = rs;
      bus.req_rt     = rt;
      bus.req_rd     = rd;
      bus.req_imm    = imm;
      bus.req_target = tgt;
   endtask

   task automatic idle_in();
      drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
   endtask

   // One clock: sample/check at the falling edge, advance the model, settle 1ns past the rising edge.
   task automatic cycle(input bit do_chk);
      bit ready_e;
      bit we_e;
      @(negedge clk);
      ready_e    = !m_pending && (m_count < DEPTH) && !rst && !clr;
      we_e       = m_pending && !rst && !clr;
      seen_we    = bus.imem_we;
      seen_word  = bus.imem_wdata;
      seen_addr  = bus.imem_addr;
      seen_count = 32'(bus.word_count);
      seen_err   = bus.err_illegal;
      seen_full  = bus.full;
      seen_ready = bus.req_ready;
      if (bus.imem_we) begin
         we_pulses++;
         $display("write  addr=0x%08h data=0x%08h count=%0d", bus.imem_addr, bus.imem_wdata, bus.word_count);
      end
      if (do_chk) begin
         chk("req_ready", 32'(seen_ready), 32'(ready_e));
         chk("imem_we", 32'(seen_we), 32'(we_e));
         chk("imem_addr", seen_addr, m_addr);
         chk("word_count", seen_count, 32'(m_count));
         chk("full", 32'(seen_full), 32'(m_count == DEPTH));
         chk("err_illegal", 32'(seen_err), 32'(m_err));
         if (m_word_chk) chk("imem_wdata", seen_word, m_word);
      end
      if (rst) begin
         m_pending = 0; m_addr = BASE; m_word = '0; m_word_chk = 1; m_count = 0; m_err = 0;
      end else if (clr) begin
         m_pending = 0; m_addr = BASE; m_count = 0; m_err = 0; m_word_chk = 0;
      end else if (m_pending) begin
         m_pending = 0; m_addr = m_addr + 32'd4; m_count++; m_err = 0;
      end else if (ready_e && bus.req_valid) begin
         if (bus.req_op <= 4'd9) begin
            m_word = enc(bus.req_op, bus.req_rs, bus.req_rt, bus.req_rd, bus.req_imm, bus.req_target);
            m_word_chk = 1; m_pending = 1; m_err = 0;
         end else begin
            m_err = 1;
         end
      end else begin
         m_err = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      idle_in();
      clr = 1'b1;
      cycle(1);
      clr = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{4'd0, 5'd1,  5'd2,  5'd3,  16'hABCD, 26'h155,     32'h00221820};
      tbl[1]  = '{4'd5, 5'd0,  5'd8,  5'd17, 16'h0004, 26'h3FF,     32'h8C080004};
      tbl[2]  = '{4'd7, 5'd1,  5'd2,  5'd9,  16'hFFFF, 26'h0,       32'h1022FFFF};
      tbl[3]  = '{4'd9, 5'd7,  5'd7,  5'd7,  16'h1234, 26'h10,      32'h08000010};
      tbl[4]  = '{4'd1, 5'd4,  5'd5,  5'd6,  16'h0,    26'h0,       32'h00853022};
      tbl[5]  = '{4'd2, 5'd31, 5'd0,  5'd31, 16'h0,    26'h0,       32'h03E0F824};
      tbl[6]  = '{4'd3, 5'd7,  5'd8,  5'd9,  16'h0,    26'h0,       32'h00E84825};
      tbl[7]  = '{4'd4, 5'd2,  5'd3,  5'd1,  16'h0,    26'h0,       32'h0043082A};
      tbl[8]  = '{4'd6, 5'd29, 5'd31, 5'd0,  16'h0010, 26'h0,       32'hAFBF0010};
      tbl[9]  = '{4'd8, 5'd0,  5'd1,  5'd7,  16'h8000, 26'h0,       32'h20018000};
      tbl[10] = '{4'd9, 5'd0,  5'd0,  5'd0,  16'h0,    26'h3FFFFFF, 32'h0BFFFFFF};

      m_pending = 0; m_word = '0; m_word_chk = 0; m_addr = '0; m_count = 0; m_err = 0;
      we_pulses = 0;
      rst = 1'b1;
      clr = 1'b0;
      idle_in();
      cycle(0);
      cycle(1);
      rst = 1'b0;
      cycle(1);

      // Encoding table, one request per entry.
      for (int i = 0; i < 11; i++) begin
         if (m_count == DEPTH) do_clr();
         drive(1'b1, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].tgt);
         cycle(1);
         idle_in();
         cycle(1);
         chk("tbl_we", 32'(seen_we), 32'd1);
         chk("tbl_word", seen_word, tbl[i].exp);
      end

      // Illegal op: pulse, no write, address and count untouched.
      do_clr();
      drive(1'b1, 4'd12, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1);
      cycle(1);
      idle_in();
      cycle(1);
      chk("illegal_err", 32'(seen_err), 32'd1);
      chk("illegal_we", 32'(seen_we), 32'd0);
      chk("illegal_addr", seen_addr, BASE);
      chk("illegal_count", seen_count, 32'd0);
      cycle(1);
      chk("illegal_err_clears", 32'(seen_err), 32'd0);

      // Valid held high across more ops than fit.
      do_clr();
      we_pulses = 0;
      for (int k = 0; k < 12; k++) begin
         drive(1'b1, 4'(k % 10), 5'(k), 5'(k + 1), 5'(k + 2), 16'(k * 3), 26'(k * 5));
         cycle(1);
      end
      idle_in();
      cycle(1);
      chk("fill_writes", 32'(we_pulses), 32'd4);
      chk("fill_full", 32'(seen_full), 32'd1);
      chk("fill_ready", 32'(seen_ready), 32'd0);
      chk("fill_addr", seen_addr, BASE + 32'd16);

      // clr landing on the write cycle drops that word.
      do_clr();
      drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      cycle(1);
      idle_in();
      clr = 1'b1;
      cycle(1);
      chk("clr_abort_we", 32'(seen_we), 32'd0);
      clr = 1'b0;
      cycle(1);
      chk("clr_abort_addr", seen_addr, BASE);
      chk("clr_abort_count", seen_count, 32'd0);
      drive(1'b1, 4'd5, 5'd0, 5'd8, 5'd0, 16'h4, 26'h0);
      cycle(1);
      idle_in();
      cycle(1);
      chk("after_clr_we", 32'(seen_we), 32'd1);
      chk("after_clr_addr", seen_addr, BASE);
      chk("after_clr_word", seen_word, 32'h8C080004);

      // rst out of FULL.
      for (int k = 0; k < 9; k++) begin
         drive(1'b1, 4'd3, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
         cycle(1);
      end
      idle_in();
      cycle(1);
      chk("pre_rst_full", 32'(seen_full), 32'd1);
      rst = 1'b1;
      cycle(1);
      rst = 1'b0;
      cycle(1);
      chk("rst_full", 32'(seen_full), 32'd0);
      chk("rst_ready", 32'(seen_ready), 32'd1);
      chk("rst_wdata", seen_word, 32'h0);
      chk("rst_count", seen_count, 32'd0);

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         rst = ($urandom_range(0, 99) < 2);
         clr = ($urandom_range(0, 99) < 4);
         drive($urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom),
               5'($urandom), 16'($urandom), 26'($urandom));
         cycle(1);
      end
      rst = 1'b0;
      clr = 1'b0;
      idle_in();
      cycle(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
